// File: rtl/uart_byte_tx.sv
// uart_byte_tx
//   Serialises bytes from the upstream counter stage onto one UART TX pin.
//   Frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
//   A small FIFO with a valid/ready handshake decouples byte production from
//   the slow serial line.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   in_data     byte to transmit
//   in_valid    in_data valid this cycle
//   in_ready    FIFO can accept a byte this cycle (low while in reset)
//   parity_en   append parity bit; sampled when a byte is popped
//   parity_odd  1 = odd parity, 0 = even; sampled when a byte is popped
//   tx          serial line, idles high, registered
//   busy        high while a frame is on the line, registered
//   fifo_level  bytes queued, excluding the byte in flight
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            par_en_q;
    logic            par_bit;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      head;
    logic            push;
    logic            pop;

    // Ready comes from the registered level only, so a pop this cycle does
    // not make room until the next one.
    assign in_ready = rst_n && (fifo_level < LW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    // Pops happen only when leaving IDLE or at the last STOP cycle.
    always_comb begin
        pop = 1'b0;
        if (fifo_level != '0) begin
            if (state == IDLE) begin
                pop = 1'b1;
            end else if (state == STOP && baud_cnt == STOP_LAST) begin
                pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_en_q   <= 1'b0;
            par_bit    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                shift    <= head;
                par_en_q <= parity_en;
                // Parity bit is fixed at pop time so later input changes
                // cannot disturb the frame.
                par_bit  <= (^head) ^ parity_odd;
            end
            fifo_level <= fifo_level + LW'(push) - LW'(pop);

            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (pop) begin
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end

                START: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (par_en_q) begin
                                tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_cnt == STOP_LAST) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            // Back-to-back frame: no idle gap, busy stays high.
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx
//   Two instances: dut_a with default parameters, dut_b with CLKS_PER_BIT=2
//   and STOP_BITS=2. Frames are compared cycle by cycle against a bit list
//   built from the byte, parity settings and stop-bit count.
module tb_uart_byte_tx;

    logic       clk;
    logic       rst_n;

    logic [7:0] a_in_data, b_in_data;
    logic       a_in_valid, b_in_valid;
    logic       a_in_ready, b_in_ready;
    logic       a_pen, b_pen, a_podd, b_podd;
    logic       a_tx, b_tx, a_busy, b_busy;
    logic [2:0] a_level, b_level;

    int checks   = 0;
    int failures = 0;

    uart_byte_tx dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (a_in_data),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .parity_en  (a_pen),
        .parity_odd (a_podd),
        .tx         (a_tx),
        .busy       (a_busy),
        .fifo_level (a_level)
    );

    uart_byte_tx #(
        .CLKS_PER_BIT (2),
        .FIFO_DEPTH   (4),
        .STOP_BITS    (2)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (b_in_data),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .parity_en  (b_pen),
        .parity_odd (b_podd),
        .tx         (b_tx),
        .busy       (b_busy),
        .fifo_level (b_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic txof(input bit sel);
        return sel ? b_tx : a_tx;
    endfunction

    function automatic logic busyof(input bit sel);
        return sel ? b_busy : a_busy;
    endfunction

    function automatic logic [2:0] levelof(input bit sel);
        return sel ? b_level : a_level;
    endfunction

    task automatic drive(input bit sel, input bit v, input logic [7:0] d,
                         input bit pen, input bit podd);
        if (sel) begin
            b_in_valid = v; b_in_data = d; b_pen = pen; b_podd = podd;
        end else begin
            a_in_valid = v; a_in_data = d; a_pen = pen; a_podd = podd;
        end
    endtask

    // Compare one whole frame cycle by cycle.
    // mode 0: wait (bounded) for the start bit; mode 1: start bit must begin
    // at the next negedge; mode 2: current negedge is the first start cycle.
    task automatic check_frame(input bit sel, input logic [7:0] d, input bit pen,
                               input bit podd, input int mode);
        logic [15:0] v;
        int n;
        int cpb;
        int stops;
        int guard;
        cpb   = sel ? 2 : 4;
        stops = sel ? 2 : 1;
        v     = '0;
        v[0]  = 1'b0;
        for (int i = 0; i < 8; i++) v[1+i] = d[i];
        n = 9;
        if (pen) begin
            v[n] = (^d) ^ podd;
            n++;
        end
        for (int s = 0; s < stops; s++) begin
            v[n] = 1'b1;
            n++;
        end
        if (mode == 1) begin
            @(negedge clk);
        end else if (mode == 0) begin
            guard = 0;
            while (txof(sel) !== 1'b0 && guard < 300) begin
                @(negedge clk);
                guard++;
            end
        end
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < cpb; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                chk($sformatf("tx%0d_%02h_k%0d_c%0d", sel, d, k, c), 32'(txof(sel)), 32'(v[k]));
                chk($sformatf("busy%0d_%02h_k%0d", sel, d, k), 32'(busyof(sel)), 32'd1);
            end
        end
    endtask

    task automatic check_idle(input bit sel);
        @(negedge clk);
        chk($sformatf("idle_tx%0d", sel), 32'(txof(sel)), 32'd1);
        chk($sformatf("idle_busy%0d", sel), 32'(busyof(sel)), 32'd0);
        chk($sformatf("idle_lvl%0d", sel), 32'(levelof(sel)), 32'd0);
    endtask

    // Single byte into an idle block: accepted at E, popped at E+1, start bit
    // on the line before E+2. Parity inputs are flipped right after the pop.
    task automatic send_one(input bit sel, input logic [7:0] d, input bit pen, input bit podd);
        @(negedge clk);
        drive(sel, 1'b1, d, pen, podd);
        @(negedge clk);
        drive(sel, 1'b0, 8'h00, pen, podd);
        chk($sformatf("lat_tx%0d_%02h", sel, d), 32'(txof(sel)), 32'd1);
        chk($sformatf("lat_lvl%0d_%02h", sel, d), 32'(levelof(sel)), 32'd1);
        @(negedge clk);
        chk($sformatf("pop_lvl%0d_%02h", sel, d), 32'(levelof(sel)), 32'd0);
        drive(sel, 1'b0, 8'h00, ~pen, ~podd);
        check_frame(sel, d, pen, podd, 2);
        check_idle(sel);
    endtask

    initial begin
        bit         saw_full;
        logic [2:0] full_level;
        logic [7:0] rd;
        bit         rp, ro;

        rst_n = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_ready_a", 32'(a_in_ready), 32'd0);
        chk("rst_ready_b", 32'(b_in_ready), 32'd0);
        chk("rst_tx_a", 32'(a_tx), 32'd1);
        chk("rst_busy_a", 32'(a_busy), 32'd0);
        chk("rst_lvl_a", 32'(a_level), 32'd0);
        chk("rst_tx_b", 32'(b_tx), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst_a", 32'(a_in_ready), 32'd1);
        chk("ready_after_rst_b", 32'(b_in_ready), 32'd1);

        // Defaults, no parity
        send_one(0, 8'hA5, 1'b0, 1'b0);

        // Parity
        send_one(0, 8'hA5, 1'b1, 1'b0);
        send_one(0, 8'h07, 1'b1, 1'b1);
        send_one(0, 8'h07, 1'b1, 1'b0);

        // Backpressure: six counter values with in_valid held high
        saw_full   = 1'b0;
        full_level = '0;
        fork
            begin
                int k;
                int guard;
                k = 0;
                guard = 0;
                while (k < 6 && guard < 1000) begin
                    @(negedge clk);
                    a_in_valid = 1'b1;
                    a_in_data  = 8'(k);
                    if (!a_in_ready) begin
                        saw_full   = 1'b1;
                        full_level = a_level;
                    end else begin
                        k++;
                    end
                    guard++;
                end
                @(negedge clk);
                a_in_valid = 1'b0;
            end
            begin
                check_frame(0, 8'h00, 1'b0, 1'b0, 0);
                for (int b = 1; b < 6; b++) check_frame(0, 8'(b), 1'b0, 1'b0, 1);
            end
        join
        chk("bp_saw_full", 32'(saw_full), 32'd1);
        chk("bp_full_level", 32'(full_level), 32'd4);
        check_idle(0);

        // Reset mid-frame during DATA bit 3 with two bytes queued
        @(negedge clk); drive(0, 1'b1, 8'h11, 1'b0, 1'b0);
        @(negedge clk); drive(0, 1'b1, 8'h22, 1'b0, 1'b0);
        @(negedge clk); drive(0, 1'b1, 8'h33, 1'b0, 1'b0);
        @(negedge clk); drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (16) @(negedge clk);
        chk("mid_lvl", 32'(a_level), 32'd2);
        chk("mid_busy", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_ready", 32'(a_in_ready), 32'd0);
        chk("mrst_tx", 32'(a_tx), 32'd1);
        chk("mrst_busy", 32'(a_busy), 32'd0);
        chk("mrst_lvl", 32'(a_level), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mrst_ready_after", 32'(a_in_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("mrst_quiet_tx%0d", i), 32'(a_tx), 32'd1);
            chk($sformatf("mrst_quiet_busy%0d", i), 32'(a_busy), 32'd0);
        end
        send_one(0, 8'h3C, 1'b0, 1'b0);

        // Two stop bits, two clocks per bit, back-to-back bytes
        @(negedge clk); drive(1, 1'b1, 8'hFF, 1'b0, 1'b0);
        @(negedge clk); drive(1, 1'b1, 8'h00, 1'b0, 1'b0);
        @(negedge clk); drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("s2_lvl", 32'(b_level), 32'd1);
        check_frame(1, 8'hFF, 1'b0, 1'b0, 2);
        check_frame(1, 8'h00, 1'b0, 1'b0, 1);
        check_idle(1);

        // Push coinciding with the pop at the end of STOP
        @(negedge clk); drive(0, 1'b1, 8'h5A, 1'b0, 1'b0);
        @(negedge clk); drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        fork
            check_frame(0, 8'h5A, 1'b0, 1'b0, 2);
            begin
                repeat (10) @(negedge clk);
                drive(0, 1'b1, 8'hC3, 1'b0, 1'b0);
                @(negedge clk);
                drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
                repeat (28) @(negedge clk);
                chk("coin_pre_lvl", 32'(a_level), 32'd1);
                drive(0, 1'b1, 8'h96, 1'b0, 1'b0);
                @(negedge clk);
                drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
            end
        join
        chk("coin_lvl", 32'(a_level), 32'd1);
        check_frame(0, 8'hC3, 1'b0, 1'b0, 2);
        check_frame(0, 8'h96, 1'b0, 1'b0, 1);
        check_idle(0);

        // Randomised bytes and parity settings on both instances
        for (int i = 0; i < 8; i++) begin
            rd = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 1));
            send_one(0, rd, rp, ro);
        end
        for (int i = 0; i < 4; i++) begin
            rd = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 1));
            send_one(1, rd, rp, ro);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
Serialises 8-bit values from the up-counter stage onto a single UART TX pin (8 data bits, LSB first, optional parity, 1 or 2 stop bits). It sits directly downstream of the counter. A small FIFO with a valid/ready handshake decouples byte production from the much slower serial line. Its output drives one dedicated output pin of the tile.

Parameters:
CLKS_PER_BIT, 4, clk cycles per serial bit; legal range 2..65535.
FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst_n  input  1  synchronous active-low reset.
in_data  input  8  byte to transmit.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  FIFO can accept a byte this cycle.
parity_en  input  1  append a parity bit; sampled when a byte is popped.
parity_odd  input  1  1 = odd parity, 0 = even; sampled when a byte is popped.
tx  output  1  serial line; idles high; registered.
busy  output  1  high while a frame is on the line; registered.
fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes currently queued (excludes the byte in flight).

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. While rst_n is sampled low at an edge:
  - tx<=1, busy<=0, fifo_level<=0, FSM<=IDLE, baud and bit counters<=0, FIFO pointers cleared.
  - in_ready is forced 0 combinationally while rst_n is low.
- Reset mid-frame aborts the frame: tx is 1 after the reset edge and all queued bytes are discarded.
- Handshake:
  - in_ready = (fifo_level < FIFO_DEPTH) && rst_n. It is derived from the registered level only, so a pop in the same cycle does not raise it.
  - A push occurs on an edge where in_valid && in_ready. in_data is captured at that edge.
  - in_valid while in_ready is low has no effect; the upstream stage must hold the byte.
- FIFO:
  - Order is first-in first-out.
  - A push and a pop on the same edge leave the level unchanged.
  - A byte pushed into an empty FIFO is not poppable until the following cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, busy=0. If fifo_level>0: pop the head into an 8-bit shift register, latch parity_en and parity_odd, set tx<=0, busy<=1, go to START.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx<=shift[0].
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, shifting right after each bit. After bit 7, go to PARITY if the latched parity_en is 1, else go to STOP.
  - PARITY: tx = (^data) XOR latched_parity_odd, held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle:
    - if fifo_level>0, pop the next byte and go straight to START (no idle gap, busy stays 1);
    - else go to IDLE with busy<=0.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets at each bit boundary.
- Timing:
  - A byte accepted at edge E into an empty, idle block drives tx low starting at edge E+2: the pop occurs at E+1 and tx is registered.
  - Frame length is (1+8+parity_en+STOP_BITS)*CLKS_PER_BIT cycles exactly.
- Changing parity_en or parity_odd mid-frame does not affect the current frame.

Test Plan:
1. Defaults, no parity: push 0xA5 once. -> tx low at E+2, then the 4-cycle bit sequence 0, 1,0,1,0,0,1,0,1, 1. busy high for exactly 40 cycles, then tx=1 and busy=0.
2. Parity:
   - parity_en=1, parity_odd=0, push 0xA5 -> parity bit 0, frame 44 cycles.
   - parity_odd=1, push 0x07 -> parity bit 0 (three ones, so odd parity already satisfied).
   - parity_odd=0, push 0x07 -> parity bit 1.
3. Backpressure: hold in_valid=1 with counter values 0x00..0x05 on consecutive cycles.
   - in_ready goes low after 4 bytes are queued (fifo_level=4), accounting for the first byte popped at E+1.
   - All 6 bytes appear on tx in order with no idle cycles between frames (busy continuously high).
   - No byte is lost or duplicated.
4. Reset mid-frame: rst_n=0 for one edge during DATA bit 3 with 2 bytes queued.
   - At the next edge: tx=1, busy=0, fifo_level=0, in_ready low during reset and high after.
   - A subsequent push of 0x3C transmits cleanly.
5. STOP_BITS=2, CLKS_PER_BIT=2: push 0xFF then 0x00 back-to-back.
   - Stop period is 4 cycles; frame 1 is 22 cycles.
   - Frame 2's start bit begins the cycle after frame 1's last stop cycle.
6. Push/pop coincidence: fifo_level=1 with a pop due at the end of STOP, and a push on the same edge. -> fifo_level stays 1, and the pushed byte is the next one transmitted.
